// File: rtl/io_pkg.sv
// io_pkg: shared constants and types for the memory-mapped I/O responder.
// Offsets are byte offsets inside the 1 KiB I/O window; bits [1:0] are ignored
// by the decoder, so every constant is word aligned.
package io_pkg;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_FC00;

    localparam logic [9:0]  LED_OFS    = 10'h060;
    localparam logic [9:0]  SW_OFS     = 10'h070;
    localparam logic [9:0]  TCTRL_OFS  = 10'h080;
    localparam logic [9:0]  TLOAD_OFS  = 10'h084;
    localparam logic [9:0]  TCOUNT_OFS = 10'h088;
    localparam logic [9:0]  TSTAT_OFS  = 10'h08C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tmr_state_t;

endpackage

// File: rtl/io_timer.sv
// io_timer: prescaled down-count timer with expiry flag.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | stopped by software (or after reset); COUNT/prescaler hold
//   RUN   | prescaler running, COUNT decrements once per tick
//   DONE  | one-shot expiry reached; en cleared by hardware
//
// The prescaler counts up and ticks at PRESCALE-1, so one COUNT step takes
// exactly PRESCALE cycles and a full period is (LOAD+1)*PRESCALE cycles.
module io_timer
    import io_pkg::*;
#(
    parameter int PRESCALE = 100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wr_ctrl,
    input  logic        wr_load,
    input  logic        wr_stat,
    input  logic [31:0] wdata,
    output logic        ctrl_en,
    output logic        ctrl_ar,
    output logic [31:0] load_val,
    output logic [31:0] count,
    output logic        expired
);

    localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    tmr_state_t       state_q, state_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [31:0]      count_q, count_nxt;
    logic [31:0]      load_q, load_nxt;
    logic             en_q, en_nxt;
    logic             ar_q, ar_nxt;
    logic             exp_q, exp_nxt;
    logic             tick;
    logic             start;
    logic             stop;

    assign tick  = (pre_q == PRE_W'(PRESCALE - 1));
    assign start = wr_ctrl & wdata[0] & ~en_q;
    assign stop  = wr_ctrl & ~wdata[0];

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            count_q <= '0;
            load_q  <= '0;
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pre_q   <= pre_nxt;
            count_q <= count_nxt;
            load_q  <= load_nxt;
            en_q    <= en_nxt;
            ar_q    <= ar_nxt;
            exp_q   <= exp_nxt;
        end
    end

    // Next-state logic; a hardware expiry overrides a same-cycle W1C.
    always_comb begin
        state_nxt = state_q;
        pre_nxt   = pre_q;
        count_nxt = count_q;
        load_nxt  = load_q;
        en_nxt    = en_q;
        ar_nxt    = ar_q;
        exp_nxt   = exp_q;

        if (wr_load) load_nxt = wdata;
        if (wr_ctrl) begin
            en_nxt = wdata[0];
            ar_nxt = wdata[1];
        end
        if (wr_stat && wdata[0]) exp_nxt = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    count_nxt = load_q;
                    pre_nxt   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    pre_nxt = '0;
                    if (count_q != 32'd0) begin
                        count_nxt = count_q - 32'd1;
                    end else begin
                        exp_nxt = 1'b1;
                        if (ar_q) begin
                            count_nxt = load_q;
                        end else begin
                            state_nxt = DONE;
                            en_nxt    = 1'b0;
                        end
                    end
                end else begin
                    pre_nxt = pre_q + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ctrl_en  = en_q;
    assign ctrl_ar  = ar_q;
    assign load_val = load_q;
    assign count    = count_q;
    assign expired  = exp_q;

endmodule

// File: rtl/io_responder32.sv
// io_responder32: target of the core's IORead/IOWrite strobes for the
// 0xFFFFFC00 window. LED register, synchronized switches and a timer.
// Build option IO_RDATA_REG_EN: registers rdata (one-cycle read latency,
// value held between reads) for the pipelined core; default is combinational.
module io_responder32
    import io_pkg::*;
#(
    parameter int PRESCALE = 100,
    parameter int LED_W    = 16,
    parameter int SW_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              IORead,
    input  logic              IOWrite,
    input  logic [9:0]        addr,
    input  logic [31:0]       wdata,
    input  logic [SW_W-1:0]   switches,
    output logic [31:0]       rdata,
    output logic [LED_W-1:0]  leds,
    output logic              timer_irq
);

    logic [9:0]      word_ofs;
    logic            unused_addr_lsb;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic            wr_led, wr_ctrl, wr_load, wr_stat;
    logic            ctrl_en, ctrl_ar, expired;
    logic [31:0]     load_val, count;
    logic [31:0]     rd_mux;

    assign word_ofs        = {addr[9:2], 2'b00};
    assign unused_addr_lsb = ^addr[1:0];

    assign wr_led  = IOWrite && (word_ofs == LED_OFS);
    assign wr_ctrl = IOWrite && (word_ofs == TCTRL_OFS);
    assign wr_load = IOWrite && (word_ofs == TLOAD_OFS);
    assign wr_stat = IOWrite && (word_ofs == TSTAT_OFS);

    // LED output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    leds <= '0;
        else if (wr_led) leds <= wdata[LED_W-1:0];
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_ctrl  (wr_ctrl),
        .wr_load  (wr_load),
        .wr_stat  (wr_stat),
        .wdata    (wdata),
        .ctrl_en  (ctrl_en),
        .ctrl_ar  (ctrl_ar),
        .load_val (load_val),
        .count    (count),
        .expired  (expired)
    );

    assign timer_irq = expired;

    // Read mux over the current register state; unmapped offsets read 0.
    always_comb begin
        rd_mux = '0;
        case (word_ofs)
            LED_OFS:    rd_mux = 32'(leds);
            SW_OFS:     rd_mux = 32'(sw_sync);
            TCTRL_OFS:  rd_mux = {30'd0, ctrl_ar, ctrl_en};
            TLOAD_OFS:  rd_mux = load_val;
            TCOUNT_OFS: rd_mux = count;
            TSTAT_OFS:  rd_mux = {31'd0, expired};
            default:    rd_mux = '0;
        endcase
    end

`ifdef IO_RDATA_REG_EN
    // Capture on every read strobe and hold the value until the next read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    rdata <= '0;
        else if (IORead) rdata <= rd_mux;
    end
`else
    // Zero-latency read path for the single-cycle core.
    assign rdata = IORead ? rd_mux : 32'd0;
`endif

endmodule
